// File: rtl/sym_err_counter.sv
// Symbol error rate meter: searches the reference-to-slicer delay, locks, then counts
// symbol errors per window. Define SYM_ERR_BIT_ERR_EN to add the parallel bit-error counter.
module sym_err_counter #(
    parameter int MAX_DELAY     = 32,
    parameter int SEARCH_LEN    = 64,
    parameter int LOCK_THRESH   = 2,
    parameter int WIN_LEN       = 1048576,
    parameter int UNLOCK_THRESH = 262144,
    parameter int CNT_W         = 24
) (
    input  logic                         sys_clk,
    input  logic                         reset,
    input  logic                         sym_clk_en,
    input  logic [1:0]                   ref_sym,
    input  logic [1:0]                   rx_sym,
    input  logic                         start,
    output logic                         locked,
    output logic [$clog2(MAX_DELAY)-1:0] delay_sel,
    output logic                         search_fail,
    output logic [CNT_W-1:0]             err_count,
    output logic [CNT_W-1:0]             bit_count,
    output logic                         win_valid
);

    localparam int DW = $clog2(MAX_DELAY);
    localparam logic [CNT_W-1:0] SEARCH_LAST = CNT_W'(SEARCH_LEN - 1);
    localparam logic [CNT_W-1:0] WIN_LAST    = CNT_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0] LOCK_V      = CNT_W'(LOCK_THRESH);
    localparam logic [CNT_W-1:0] UNLOCK_V    = CNT_W'(UNLOCK_THRESH);
    localparam logic [DW-1:0]    DLY_LAST    = DW'(MAX_DELAY - 1);

    typedef enum logic [1:0] {IDLE, SEARCH, LOCKED} state_t;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    state_t                 state_q;
    logic [2*MAX_DELAY-1:0] tap_q;
    logic [DW-1:0]          delay_sel_q;
    logic                   locked_q;
    logic                   search_fail_q;
    logic                   win_valid_q;
    logic [CNT_W-1:0]       sym_cnt_q;
    logic [CNT_W-1:0]       err_cnt_q;
    logic [CNT_W-1:0]       err_count_q;

    logic [1:0]             tap_sym;
    logic [1:0]             sym_xor;
    logic                   mism;
    logic                   sym_last;
    logic [CNT_W-1:0]       err_cnt_d;

    // Compare against the tap as it stands before this strobe's shift.
    always_comb begin
        tap_sym   = tap_q[{delay_sel_q, 1'b0} +: 2];
        sym_xor   = rx_sym ^ tap_sym;
        mism      = |sym_xor;
        err_cnt_d = sat_add(err_cnt_q, {1'b0, mism});
        sym_last  = 1'b0;
        if (state_q == SEARCH)
            sym_last = (sym_cnt_q == SEARCH_LAST);
        else if (state_q == LOCKED)
            sym_last = (sym_cnt_q == WIN_LAST);
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            tap_q         <= '0;
            delay_sel_q   <= '0;
            locked_q      <= 1'b0;
            search_fail_q <= 1'b0;
            win_valid_q   <= 1'b0;
            sym_cnt_q     <= '0;
            err_cnt_q     <= '0;
            err_count_q   <= '0;
        end else begin
            win_valid_q <= 1'b0;
            if (sym_clk_en)
                tap_q <= {tap_q[2*MAX_DELAY-3:0], ref_sym};

            // start overrides everything, including a coincident window end.
            if (start) begin
                state_q       <= SEARCH;
                delay_sel_q   <= '0;
                locked_q      <= 1'b0;
                search_fail_q <= 1'b0;
                sym_cnt_q     <= '0;
                err_cnt_q     <= '0;
            end else if (sym_clk_en) begin
                case (state_q)
                    IDLE: ;
                    SEARCH: begin
                        if (sym_last) begin
                            sym_cnt_q <= '0;
                            err_cnt_q <= '0;
                            if (err_cnt_d <= LOCK_V) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                            end else if (delay_sel_q == DLY_LAST) begin
                                delay_sel_q   <= '0;
                                search_fail_q <= 1'b1;
                            end else begin
                                delay_sel_q <= delay_sel_q + 1'b1;
                            end
                        end else begin
                            sym_cnt_q <= sym_cnt_q + 1'b1;
                            err_cnt_q <= err_cnt_d;
                        end
                    end
                    LOCKED: begin
                        if (sym_last) begin
                            err_count_q <= err_cnt_d;
                            win_valid_q <= 1'b1;
                            sym_cnt_q   <= '0;
                            err_cnt_q   <= '0;
                            if (err_cnt_d > UNLOCK_V) begin
                                state_q     <= SEARCH;
                                delay_sel_q <= '0;
                                locked_q    <= 1'b0;
                            end
                        end else begin
                            sym_cnt_q <= sym_cnt_q + 1'b1;
                            err_cnt_q <= err_cnt_d;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

`ifdef SYM_ERR_BIT_ERR_EN
    function automatic logic [1:0] popcnt2(input logic [1:0] x);
        return {1'b0, x[1]} + {1'b0, x[0]};
    endfunction

    logic [CNT_W-1:0] bit_cnt_q;
    logic [CNT_W-1:0] bit_count_q;
    logic [CNT_W-1:0] bit_cnt_d;

    always_comb bit_cnt_d = sat_add(bit_cnt_q, popcnt2(sym_xor));

    // Bit errors only accumulate while locked; window control mirrors the symbol counter.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            bit_cnt_q   <= '0;
            bit_count_q <= '0;
        end else if (start) begin
            bit_cnt_q <= '0;
        end else if (sym_clk_en && state_q == LOCKED) begin
            if (sym_last) begin
                bit_count_q <= bit_cnt_d;
                bit_cnt_q   <= '0;
            end else begin
                bit_cnt_q <= bit_cnt_d;
            end
        end
    end

    assign bit_count = bit_count_q;
`else
    assign bit_count = '0;
`endif

    assign locked      = locked_q;
    assign delay_sel   = delay_sel_q;
    assign search_fail = search_fail_q;
    assign err_count   = err_count_q;
    assign win_valid   = win_valid_q;

endmodule

// File: tb/tb_sym_err_counter.sv
// Scoreboard bench for sym_err_counter: window results are queued by the stimulus and
// checked by a monitor on win_valid; status outputs are checked directly.
module tb_sym_err_counter;

    localparam int MAX_DELAY     = 32;
    localparam int SEARCH_LEN    = 64;
    localparam int LOCK_THRESH   = 2;
    localparam int WIN_LEN       = 256;
    localparam int UNLOCK_THRESH = 128;
    localparam int CNT_W         = 24;
    localparam int DW            = $clog2(MAX_DELAY);

    logic             sys_clk = 1'b0;
    logic             reset;
    logic             sym_clk_en;
    logic [1:0]       ref_sym;
    logic [1:0]       rx_sym;
    logic             start;
    logic             locked;
    logic [DW-1:0]    delay_sel;
    logic             search_fail;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] bit_count;
    logic             win_valid;

    always #5 sys_clk = ~sys_clk;

    sym_err_counter #(
        .MAX_DELAY(MAX_DELAY), .SEARCH_LEN(SEARCH_LEN), .LOCK_THRESH(LOCK_THRESH),
        .WIN_LEN(WIN_LEN), .UNLOCK_THRESH(UNLOCK_THRESH), .CNT_W(CNT_W)
    ) dut (
        .sys_clk(sys_clk), .reset(reset), .sym_clk_en(sym_clk_en), .ref_sym(ref_sym),
        .rx_sym(rx_sym), .start(start), .locked(locked), .delay_sel(delay_sel),
        .search_fail(search_fail), .err_count(err_count), .bit_count(bit_count),
        .win_valid(win_valid)
    );

    typedef struct {
        int   err;
        int   bits;
        logic lk;
    } win_t;

    win_t       sb_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         gap      = 0;
    logic [1:0] hist[64];   // hist[k] = ref_sym strobed k+1 symbols ago

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Tap k holds the reference from k+1 strobes ago; alignment at tap 7 = hist[7].
    task automatic prep(input int mode, input logic [1:0] mask,
                        output logic [1:0] rx, output int e, output int b);
        logic [1:0] want;
        want = hist[7];
        case (mode)
            0:       rx = want ^ mask;
            1:       rx = 2'b00;
            default: rx = 2'($urandom_range(0, 3));
        endcase
        e = (rx != want) ? 1 : 0;
        b = ((rx[0] != want[0]) ? 1 : 0) + ((rx[1] != want[1]) ? 1 : 0);
    endtask

    task automatic drive(input logic [1:0] rx, input logic st);
        ref_sym    = 2'($urandom_range(0, 3));
        rx_sym     = rx;
        sym_clk_en = 1'b1;
        start      = st;
        @(negedge sys_clk);
        sym_clk_en = 1'b0;
        start      = 1'b0;
        for (int k = 63; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = ref_sym;
        repeat (gap) @(negedge sys_clk);
    endtask

    task automatic run(input int mode, input int n);
        logic [1:0] rx;
        int e, b;
        for (int i = 0; i < n; i++) begin
            prep(mode, 2'b00, rx, e, b);
            drive(rx, 1'b0);
        end
    endtask

    task automatic window(input int mode, input int n1, input int n2, output int tot);
        logic [1:0] rx, m;
        int e, b, se, sbits;
        win_t w;
        se = 0;
        sbits = 0;
        for (int i = 0; i < WIN_LEN; i++) begin
            m = (i < n1) ? 2'b01 : (i < n1 + n2) ? 2'b11 : 2'b00;
            prep(mode, m, rx, e, b);
            se += e;
            sbits += b;
            if (i == WIN_LEN - 1) begin
                w.err = se;
`ifdef SYM_ERR_BIT_ERR_EN
                w.bits = sbits;
`else
                w.bits = 0;
`endif
                w.lk = (se <= UNLOCK_THRESH);
                sb_q.push_back(w);
            end
            drive(rx, 1'b0);
        end
        tot = se;
    endtask

    always @(negedge sys_clk) begin
        if (reset === 1'b0 && win_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_win_valid: got win_valid=1 with err_count=%0d, expected no window", err_count);
            end else begin
                win_t w;
                w = sb_q.pop_front();
                check("win_err_count", err_count, w.err);
                check("win_bit_count", bit_count, w.bits);
                check("win_locked", locked, w.lk);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] rx;
        int e, b, held;
        reset = 1'b1; start = 1'b0; sym_clk_en = 1'b0; ref_sym = 2'b00; rx_sym = 2'b00;
        for (int k = 0; k < 64; k++) hist[k] = 2'b00;
        repeat (3) @(negedge sys_clk);
        check("rst_locked", locked, 0);
        check("rst_delay_sel", delay_sel, 0);
        check("rst_search_fail", search_fail, 0);
        check("rst_err_count", err_count, 0);
        check("rst_bit_count", bit_count, 0);
        check("rst_win_valid", win_valid, 0);
        reset = 1'b0;
        @(negedge sys_clk);

        // Idle: strobes are ignored apart from filling the delay line.
        run(0, 20);
        check("idle_locked", locked, 0);
        check("idle_delay_sel", delay_sel, 0);

        // Search with a one-cycle gap between strobes.
        gap = 1;
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        check("start_delay_sel", delay_sel, 0);
        run(0, 8 * SEARCH_LEN - 1);
        check("pre_lock_locked", locked, 0);
        check("pre_lock_delay_sel", delay_sel, 7);
        run(0, 1);
        check("lock_locked", locked, 1);
        check("lock_delay_sel", delay_sel, 7);
        check("lock_search_fail", search_fail, 0);
        gap = 0;

        window(0, 0, 0, e);       // clean
        window(0, 90, 10, e);     // 100 symbol errors, 110 bit errors
        window(0, 10, 5, e);      // 15 symbol errors, 20 bit errors
        window(0, 128, 0, e);     // exactly at the unlock threshold
        check("thresh_locked", locked, 1);
        window(1, 0, 0, held);    // constant 00: about 3/4 of symbols wrong
        check("const_locked", locked, (held <= UNLOCK_THRESH) ? 1 : 0);
        check("const_delay_sel", delay_sel, (held <= UNLOCK_THRESH) ? 7 : 0);

        // Uncorrelated receive data sweeps every delay without locking.
        run(2, MAX_DELAY * SEARCH_LEN - 1);
        check("sweep_search_fail", search_fail, 0);
        check("sweep_delay_sel", delay_sel, MAX_DELAY - 1);
        run(2, 1);
        check("fail_search_fail", search_fail, 1);
        check("fail_delay_sel", delay_sel, 0);
        check("fail_locked", locked, 0);
        check("fail_err_held", err_count, held);

        // start with a coincident strobe: that symbol must not be counted.
        prep(0, 2'b00, rx, e, b);
        drive(rx, 1'b1);
        check("restart_search_fail", search_fail, 0);
        run(0, 8 * SEARCH_LEN - 1);
        check("restart_pre_locked", locked, 0);
        run(0, 1);
        check("restart_locked", locked, 1);
        check("restart_delay_sel", delay_sel, 7);

        // Window end coinciding with start is discarded.
        run(0, WIN_LEN - 1);
        prep(0, 2'b00, rx, e, b);
        drive(rx, 1'b1);
        check("discard_win_valid", win_valid, 0);
        check("discard_locked", locked, 0);
        check("discard_err_held", err_count, held);

        // Relock, then reset part way through a window.
        run(0, 8 * SEARCH_LEN);
        check("relock_locked", locked, 1);
        run(0, 100);
        reset = 1'b1;
        #1;
        check("midrst_locked", locked, 0);
        check("midrst_delay_sel", delay_sel, 0);
        check("midrst_err_count", err_count, 0);
        check("midrst_bit_count", bit_count, 0);
        for (int k = 0; k < 64; k++) hist[k] = 2'b00;
        @(negedge sys_clk);
        reset = 1'b0;
        @(negedge sys_clk);
        run(0, 300);
        check("post_rst_locked", locked, 0);
        check("post_rst_delay_sel", delay_sel, 0);
        check("post_rst_search_fail", search_fail, 0);
        repeat (3) @(negedge sys_clk);
        check("pending_windows", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
